// File: rtl/store_merge_buffer.sv
// Write-combining store buffer: merges LSU stores into line entries
// and drains whole lines in FIFO order over a valid/ready port.
module store_merge_buffer #(
    parameter int Offset_len = 6,
    parameter int Addr_width = 32,
    parameter int Entries    = 4,
    parameter int Timeout    = 15
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         st_valid,
    output logic                         st_ready,
    input  logic [Addr_width-1:0]        st_addr,
    input  logic [31:0]                  st_data,
    input  logic [1:0]                   st_size,
    input  logic                         flush,
    output logic                         flush_done,
    output logic                         wb_valid,
    input  logic                         wb_ready,
    output logic [Addr_width-1:0]        wb_addr,
    output logic [(8<<Offset_len)-1:0]   wb_data,
    output logic [(1<<Offset_len)-1:0]   wb_strb,
    output logic                         empty,
    output logic                         misalign_err
);
    localparam int LINE_BYTES = 1 << Offset_len;
    localparam int LINE_BITS  = LINE_BYTES * 8;
    localparam int TAG_W      = Addr_width - Offset_len;
    localparam int PW         = $clog2(Entries);
    localparam int AGE_W      = $clog2(Timeout + 1);

    localparam logic [PW:0]      CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]      CNT_TWO  = (PW+1)'(2);
    localparam logic [PW:0]      CNT_FULL = (PW+1)'(Entries);
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(Timeout);

    typedef enum logic {IDLE, ISSUE} state_t;

    logic [TAG_W-1:0]      tag_q  [Entries];
    logic [LINE_BITS-1:0]  data_q [Entries];
    logic [LINE_BYTES-1:0] strb_q [Entries];

    logic [PW-1:0]    head, tail, young;
    logic [PW:0]      count, count_nxt;
    logic [AGE_W-1:0] age;
    logic             flush_pending;
    state_t           state;

    logic [TAG_W-1:0]      st_tag;
    logic [Offset_len-1:0] st_off;
    logic [3:0]            size_mask;
    logic [31:0]           size_data;
    logic [LINE_BYTES-1:0] wr_strb;
    logic [LINE_BITS-1:0]  wr_data, wr_bits;
    logic misalign, locked, hit, accept;
    logic do_merge, do_alloc, drain, flush_req, issue_cond;

    assign st_tag = st_addr[Addr_width-1:Offset_len];
    assign st_off = st_addr[Offset_len-1:0];

    always_comb begin
        size_mask = '0;
        size_data = '0;
        misalign  = 1'b0;
        unique case (st_size)
            2'd0: begin
                size_mask = 4'b0001;
                size_data = {24'b0, st_data[7:0]};
            end
            2'd1: begin
                size_mask = 4'b0011;
                size_data = {16'b0, st_data[15:0]};
                misalign  = st_addr[0];
            end
            2'd2: begin
                size_mask = 4'b1111;
                size_data = st_data;
                misalign  = |st_addr[1:0];
            end
            2'd3: misalign = 1'b1;
        endcase
    end

    assign wr_strb = LINE_BYTES'(size_mask) << st_off;
    assign wr_data = LINE_BITS'(size_data) << {st_off, 3'b000};

    always_comb begin
        wr_bits = '0;
        for (int i = 0; i < LINE_BYTES; i++)
            wr_bits[8*i +: 8] = {8{wr_strb[i]}};
    end

    // The line on offer is frozen; a store to its tag opens a new entry.
    assign young  = tail - PW'(1);
    assign locked = wb_valid && (young == head);
    assign hit    = (count != '0) && (tag_q[young] == st_tag) && !locked;

    assign st_ready  = !flush_pending && (hit || count < CNT_FULL);
    assign accept    = st_valid && st_ready;
    assign do_merge  = accept && !misalign && hit;
    assign do_alloc  = accept && !misalign && !hit;
    assign drain     = wb_valid && wb_ready;
    assign count_nxt = count + (PW+1)'(do_alloc) - (PW+1)'(drain);
    assign flush_req = flush || flush_pending;

    assign issue_cond = (count >= CNT_TWO)
                     || (count == CNT_ONE && age >= AGE_MAX)
                     || (flush_pending && count != '0);

    assign wb_addr = {tag_q[head], {Offset_len{1'b0}}};
    assign wb_data = data_q[head];
    assign wb_strb = strb_q[head];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < Entries; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
                strb_q[i] <= '0;
            end
        end else begin
            if (drain) begin
                data_q[head] <= '0;
                strb_q[head] <= '0;
            end
            if (do_alloc) begin
                tag_q[tail]  <= st_tag;
                data_q[tail] <= wr_data;
                strb_q[tail] <= wr_strb;
            end else if (do_merge) begin
                data_q[young] <= (data_q[young] & ~wr_bits) | wr_data;
                strb_q[young] <= strb_q[young] | wr_strb;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            age           <= '0;
            flush_pending <= 1'b0;
            flush_done    <= 1'b0;
            misalign_err  <= 1'b0;
            empty         <= 1'b1;
            state         <= IDLE;
            wb_valid      <= 1'b0;
        end else begin
            if (do_alloc) tail <= tail + PW'(1);
            if (drain)    head <= head + PW'(1);
            count <= count_nxt;

            if (accept || count_nxt != count || count != CNT_ONE)
                age <= '0;
            else if (age < AGE_MAX)
                age <= age + AGE_W'(1);

            flush_pending <= flush_req && (count_nxt != '0);
            flush_done    <= flush_req && (count_nxt == '0);
            misalign_err  <= accept && misalign;
            empty         <= (count_nxt == '0);

            unique case (state)
                IDLE: if (issue_cond) begin
                    state    <= ISSUE;
                    wb_valid <= 1'b1;
                end
                ISSUE: if (wb_ready) begin
                    state    <= IDLE;
                    wb_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_merge_buffer.sv
// Randomised bench for store_merge_buffer with a line-queue
// reference model and a write-back scoreboard.
module tb_store_merge_buffer;
    localparam int OFF = 6;
    localparam int AW  = 32;
    localparam int ENT = 4;
    localparam int TO  = 15;
    localparam int LB  = 1 << OFF;

    typedef struct packed {
        logic [AW-OFF-1:0] tag;
        logic [LB*8-1:0]   data;
        logic [LB-1:0]     strb;
    } line_t;

    logic            clk = 1'b0;
    logic            rstn;
    logic            st_valid, st_ready;
    logic [AW-1:0]   st_addr;
    logic [31:0]     st_data;
    logic [1:0]      st_size;
    logic            flush, flush_done;
    logic            wb_valid, wb_ready;
    logic [AW-1:0]   wb_addr;
    logic [LB*8-1:0] wb_data;
    logic [LB-1:0]   wb_strb;
    logic            empty, misalign_err;

    store_merge_buffer #(
        .Offset_len(OFF), .Addr_width(AW), .Entries(ENT), .Timeout(TO)
    ) dut (
        .clk(clk), .rstn(rstn),
        .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
        .flush(flush), .flush_done(flush_done),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_addr(wb_addr), .wb_data(wb_data), .wb_strb(wb_strb),
        .empty(empty), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int nwb    = 0;

    line_t mlines[$];
    line_t exp_q[$];
    logic  m_pend, m_fd, m_mis, m_empty;
    logic  obs_wbv;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mlines.delete();
        exp_q.delete();
        m_pend  = 1'b0;
        m_fd    = 1'b0;
        m_mis   = 1'b0;
        m_empty = 1'b1;
    endtask

    // One clock cycle: drive, check registered outputs, advance the model.
    task automatic cycle(input logic v, input logic [AW-1:0] a,
                         input logic [1:0] sz, input logic [31:0] d,
                         input logic fl, input logic wr);
        logic  hit, rdy, acc, mis;
        int    nb, off;
        line_t ln;
        @(negedge clk);
        st_valid = v;
        st_addr  = a;
        st_size  = sz;
        st_data  = d;
        flush    = fl;
        wb_ready = wr;
        #1;
        chk("empty", 64'(empty), 64'(m_empty));
        chk("flush_done", 64'(flush_done), 64'(m_fd));
        chk("misalign_err", 64'(misalign_err), 64'(m_mis));
        if (mlines.size() == 0)
            chk("wb_valid_idle", 64'(wb_valid), 64'd0);
        obs_wbv = wb_valid;
        hit = 1'b0;
        if (mlines.size() > 0)
            hit = (mlines[$].tag == a[AW-1:OFF])
               && !(wb_valid && mlines.size() == 1);
        rdy = !m_pend && (hit || mlines.size() < ENT);
        chk("st_ready", 64'(st_ready), 64'(rdy));
        acc = v && rdy;
        if (wb_valid && wr && mlines.size() > 0)
            exp_q.push_back(mlines.pop_front());
        mis = (sz == 2'd3) || (sz == 2'd1 && a[0])
           || (sz == 2'd2 && a[1:0] != 2'b00);
        m_mis = acc && mis;
        if (acc && !mis) begin
            nb  = 1 << sz;
            off = int'(a[OFF-1:0]);
            if (hit) begin
                ln = mlines.pop_back();
            end else begin
                ln.tag  = a[AW-1:OFF];
                ln.data = '0;
                ln.strb = '0;
            end
            for (int k = 0; k < nb; k++) begin
                ln.data[8*(off+k) +: 8] = d[8*k +: 8];
                ln.strb[off+k] = 1'b1;
            end
            mlines.push_back(ln);
        end
        m_fd    = (m_pend || fl) && mlines.size() == 0;
        m_pend  = (m_pend || fl) && mlines.size() != 0;
        m_empty = mlines.size() == 0;
    endtask

    task automatic idle(input logic wr);
        cycle(1'b0, '0, 2'd0, '0, 1'b0, wr);
    endtask

    // Scoreboard monitor: compares every accepted write-back line.
    initial begin
        line_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rstn && wb_valid && wb_ready) begin
                nwb++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_unexpected addr=%0h", wb_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_addr", 64'(wb_addr), 64'({e.tag, 6'b0}));
                    chk("wb_strb", 64'(wb_strb), 64'(e.strb));
                    checks++;
                    if (wb_data !== e.data) begin
                        errors++;
                        $display("FAIL wb_data got=%h want=%h",
                                 wb_data, e.data);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        logic seen;
        logic [AW-1:0] bases [4];
        logic [AW-1:0] a;
        logic [1:0] sz;
        logic wr;
        bases[0] = 32'h1000;
        bases[1] = 32'h1040;
        bases[2] = 32'h2000;
        bases[3] = 32'h30c0;

        rstn = 1'b0;
        st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0;
        flush = 1'b0; wb_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_st_ready", 64'(st_ready), 64'd1);
        chk("rst_flush_done", 64'(flush_done), 64'd0);
        chk("rst_misalign", 64'(misalign_err), 64'd0);
        rstn = 1'b1;

        // Three merging stores to one line, then the lone-entry timeout.
        cycle(1'b1, 32'h1003, 2'd0, 32'h000000aa, 1'b0, 1'b1);
        cycle(1'b1, 32'h1000, 2'd1, 32'h0000beef, 1'b0, 1'b1);
        cycle(1'b1, 32'h1008, 2'd2, 32'h11223344, 1'b0, 1'b1);
        n = 0;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            idle(1'b1);
            if (obs_wbv) n = i;
        end
        chk("timeout_latency", 64'(n), 64'(TO + 2));
        repeat (3) idle(1'b1);

        // Store to the tag of the line on offer opens a new entry.
        cycle(1'b1, 32'h3000, 2'd2, 32'hcafef00d, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            idle(1'b0);
            seen = obs_wbv;
        end
        chk("locked_wait", 64'(seen), 64'd1);
        cycle(1'b1, 32'h3004, 2'd0, 32'h00000077, 1'b0, 1'b0);
        repeat (40) idle(1'b1);

        // Misaligned half and reserved size are dropped.
        cycle(1'b1, 32'h2001, 2'd1, 32'h1234, 1'b0, 1'b1);
        cycle(1'b1, 32'h2000, 2'd3, 32'h5678, 1'b0, 1'b1);
        repeat (3) idle(1'b1);

        // Full buffer stalls, then flush with a toggling wb_ready.
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 32'h4000 + 32'(i * 64), 2'd2, $urandom, 1'b0, 1'b0);
        cycle(1'b0, '0, 2'd0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++)
            cycle(1'b1, 32'h5000, 2'd2, $urandom, 1'b0, 1'(i % 2));
        repeat (40) idle(1'b1);

        // Randomised traffic with varying back-pressure.
        for (int i = 0; i < 1500; i++) begin
            a  = bases[$urandom % 4] + 32'($urandom % LB);
            n  = int'($urandom % 16);
            sz = (n < 5) ? 2'd0 : (n < 10) ? 2'd1 : (n < 15) ? 2'd2 : 2'd3;
            if (sz != 2'd3 && ($urandom % 8) != 0)
                a = a & ~((32'd1 << sz) - 32'd1);
            if (sz == 2'd2 && a[OFF-1:0] > 6'(LB - 4))
                a = a - 32'd4;
            case (i / 300)
                0:       wr = ($urandom % 10) < 9;
                1:       wr = ($urandom % 10) < 3;
                2:       wr = ($urandom % 10) < 1;
                default: wr = ($urandom % 2) == 1;
            endcase
            cycle(($urandom % 2) == 1, a, sz, $urandom,
                  ($urandom % 50) == 0, wr);
        end

        for (int i = 0; i < 300 && (mlines.size() + exp_q.size()) != 0; i++)
            idle(1'b1);
        repeat (3) idle(1'b1);
        chk("final_drain", 64'(mlines.size() + exp_q.size()), 64'd0);

        // Asynchronous reset while a line is on offer.
        cycle(1'b1, 32'h6000, 2'd2, 32'h1, 1'b0, 1'b0);
        cycle(1'b1, 32'h6040, 2'd2, 32'h2, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            idle(1'b0);
            seen = obs_wbv;
        end
        chk("pre_reset_wb_valid", 64'(seen), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("async_rst_empty", 64'(empty), 64'd1);
        chk("async_rst_st_ready", 64'(st_ready), 64'd1);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            idle(1'b1);
            seen = seen | obs_wbv;
        end
        chk("no_wb_after_reset", 64'(seen), 64'd0);
        chk("wb_seen", 64'(nwb > 10), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
